ram_wr_ctrl: RTL and testbench

- Write-side controller and loopback checker for the 64x8 dual-port RAM.
- On a start request it fills the RAM with a per-frame pattern through port A.
- It then hands port B to the existing RAM reader by holding rd_flag for exactly one read sweep.
- It checks the returned read data against the expected pattern and reports done/err per frame.

---
 rtl/ram_wr_ctrl.sv | 155 +++++++++++++++
 tb/tb_ram_wr_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wr_ctrl.sv
// Write-side controller and loopback checker for a DEPTH x DATA_W dual-port RAM.
// Fills port A with (seed + addr), grants one port-B read sweep, checks the returned data.
module ram_wr_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_wr_en,
  output logic              ram_wr_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              rd_flag,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [6:0]        err_cnt,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] exp_data;
  logic [ADDR_W-1:0] exp_addr;
  logic [RD_LAT-1:0] vld_pipe;
  logic              cmp_vld;
  logic              mismatch;

  // State register and sweep counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter wraps to 0 at the end of each sweep
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = WRITE;
        else       state_nxt = IDLE;
      end
      WRITE: begin
        cnt_nxt = cnt + ONE;
        if (cnt == LAST_ADDR) state_nxt = READ;
        else                  state_nxt = WRITE;
      end
      READ: begin
        cnt_nxt = cnt + ONE;
        if (cnt == LAST_ADDR) state_nxt = DRAIN;
        else                  state_nxt = READ;
      end
      DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = DRAIN;
          cnt_nxt   = cnt + ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The compare slot trails the reader enable by exactly RD_LAT cycles
  assign cmp_vld  = vld_pipe[RD_LAT-1];
  assign exp_data = seed + DATA_W'(exp_addr);
  assign mismatch = cmp_vld && (ram_rd_data != exp_data);

  // Registered outputs, seed capture and loopback checker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_wr_en   <= 1'b0;
      ram_wr_we   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      rd_flag     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_cnt     <= 7'd0;
      frame_cnt   <= 8'd0;
      seed        <= '0;
      exp_addr    <= '0;
      vld_pipe    <= '0;
    end else begin
      ram_wr_en   <= (state == WRITE);
      ram_wr_we   <= (state == WRITE);
      ram_wr_addr <= (state == WRITE) ? cnt : '0;
      ram_wr_data <= (state == WRITE) ? (seed + DATA_W'(cnt)) : '0;
      rd_flag     <= (state == READ);
      busy        <= (state_nxt != IDLE);
      done        <= (state == DONE);

      vld_pipe[0] <= rd_flag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end

      if (state == DONE) begin
        frame_cnt <= frame_cnt + 8'd1;
      end

      if ((state == IDLE) && start) begin
        seed     <= DATA_W'(frame_cnt);
        err      <= 1'b0;
        err_cnt  <= 7'd0;
        exp_addr <= '0;
      end else if (cmp_vld) begin
        exp_addr <= exp_addr + ONE;
        if (mismatch) begin
          err <= 1'b1;
          if (err_cnt != 7'd127) begin
            err_cnt <= err_cnt + 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Directed bench for ram_wr_ctrl: RD_LAT=1 and RD_LAT=3 instances, each with its own RAM/reader model.
module tb_ram_wr_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel   = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  logic          wr_en1, wr_we1, rd_flag1, busy1, done1, err1;
  logic [AW-1:0] wr_addr1;
  logic [DW-1:0] wr_data1, rd_data1;
  logic [6:0]    err_cnt1;
  logic [7:0]    frame_cnt1;
  logic          wr_en3, wr_we3, rd_flag3, busy3, done3, err3;
  logic [AW-1:0] wr_addr3;
  logic [DW-1:0] wr_data3, rd_data3;
  logic [6:0]    err_cnt3;
  logic [7:0]    frame_cnt3;

  ram_wr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_wr_en(wr_en1), .ram_wr_we(wr_we1), .ram_wr_addr(wr_addr1), .ram_wr_data(wr_data1),
    .rd_flag(rd_flag1), .ram_rd_data(rd_data1), .busy(busy1), .done(done1),
    .err(err1), .err_cnt(err_cnt1), .frame_cnt(frame_cnt1)
  );

  ram_wr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_wr_en(wr_en3), .ram_wr_we(wr_we3), .ram_wr_addr(wr_addr3), .ram_wr_data(wr_data3),
    .rd_flag(rd_flag3), .ram_rd_data(rd_data3), .busy(busy3), .done(done3),
    .err(err3), .err_cnt(err_cnt3), .frame_cnt(frame_cnt3)
  );

  // RAM + reader model, 1-cycle read latency; corrupt1 flips addr 5 and 63
  logic [DW-1:0] mem1 [DEPTH];
  logic [AW-1:0] rptr1;
  logic          corrupt1 = 1'b0;
  always @(posedge clk) begin
    if (wr_en1 && wr_we1) mem1[wr_addr1] <= wr_data1;
    if (!rst_n) begin
      rptr1    <= '0;
      rd_data1 <= '0;
    end else if (rd_flag1) begin
      rptr1    <= rptr1 + 6'd1;
      rd_data1 <= mem1[rptr1] ^ ((corrupt1 && (rptr1 == 6'd5 || rptr1 == 6'd63)) ? 8'hA5 : 8'h00);
    end
  end

  // RAM + reader model, 3-cycle read latency; corrupt3 flips addr 0 and 63
  logic [DW-1:0] mem3 [DEPTH];
  logic [AW-1:0] rptr3;
  logic [DW-1:0] q1, q2;
  logic          corrupt3 = 1'b0;
  always @(posedge clk) begin
    if (wr_en3 && wr_we3) mem3[wr_addr3] <= wr_data3;
    if (!rst_n) begin
      rptr3    <= '0;
      q1       <= '0;
      q2       <= '0;
      rd_data3 <= '0;
    end else begin
      if (rd_flag3) begin
        rptr3 <= rptr3 + 6'd1;
        q1    <= mem3[rptr3] ^ ((corrupt3 && (rptr3 == 6'd0 || rptr3 == 6'd63)) ? 8'h3C : 8'h00);
      end
      q2       <= q1;
      rd_data3 <= q2;
    end
  end

  logic          o_wr_en, o_wr_we, o_rd_flag, o_busy, o_done, o_err;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [6:0]    o_err_cnt;
  logic [7:0]    o_frame_cnt;
  logic [34:0]   o_all;
  assign o_wr_en     = sel ? wr_en3     : wr_en1;
  assign o_wr_we     = sel ? wr_we3     : wr_we1;
  assign o_rd_flag   = sel ? rd_flag3   : rd_flag1;
  assign o_busy      = sel ? busy3      : busy1;
  assign o_done      = sel ? done3      : done1;
  assign o_err       = sel ? err3       : err1;
  assign o_addr      = sel ? wr_addr3   : wr_addr1;
  assign o_data      = sel ? wr_data3   : wr_data1;
  assign o_err_cnt   = sel ? err_cnt3   : err_cnt1;
  assign o_frame_cnt = sel ? frame_cnt3 : frame_cnt1;
  assign o_all = {o_wr_en, o_wr_we, o_addr, o_data, o_rd_flag, o_busy, o_done, o_err, o_err_cnt, o_frame_cnt};

  // Observes one frame edge by edge; edge 0 is the edge that samples start
  task automatic frame_watch(input logic [7:0] seed, input int lat, input bit hold,
                             input int upto, input int exp_errs);
    int         last;
    logic       exp_wr, exp_rd, exp_busy, exp_done;
    logic [7:0] exp_d;
    last = 2 * DEPTH + lat + 1;
    for (int e = 0; (e <= last) && (e <= upto); e++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      exp_wr   = (e >= 1) && (e <= DEPTH);
      exp_rd   = (e > DEPTH) && (e <= 2 * DEPTH);
      exp_busy = (e < last);
      exp_done = (e == last);
      exp_d    = seed + 8'(e - 1);
      checks++;
      if (o_busy !== exp_busy) begin
        fails++; $display("FAIL busy seed=%0h edge=%0d got %b want %b", seed, e, o_busy, exp_busy);
      end
      checks++;
      if (o_wr_en !== exp_wr || o_wr_we !== exp_wr) begin
        fails++; $display("FAIL wr_en seed=%0h edge=%0d got en=%b we=%b want %b", seed, e, o_wr_en, o_wr_we, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (o_addr !== 6'(e - 1) || o_data !== exp_d) begin
          fails++; $display("FAIL wr_word seed=%0h edge=%0d got %0d:%h want %0d:%h", seed, e, o_addr, o_data, e - 1, exp_d);
        end
      end
      checks++;
      if (o_rd_flag !== exp_rd) begin
        fails++; $display("FAIL rd_flag seed=%0h edge=%0d got %b want %b", seed, e, o_rd_flag, exp_rd);
      end
      checks++;
      if (o_done !== exp_done) begin
        fails++; $display("FAIL done seed=%0h edge=%0d got %b want %b", seed, e, o_done, exp_done);
      end
      if (e == 0) begin
        checks++;
        if (o_err !== 1'b0 || o_err_cnt !== 7'd0) begin
          fails++; $display("FAIL err_clear seed=%0h got %b/%0d want 0/0", seed, o_err, o_err_cnt);
        end
      end
    end
    if (upto >= last) begin
      checks++;
      if (o_err !== (exp_errs != 0) || o_err_cnt !== 7'(exp_errs)) begin
        fails++; $display("FAIL err_end seed=%0h got %b/%0d want %b/%0d", seed, o_err, o_err_cnt, exp_errs != 0, exp_errs);
      end
      checks++;
      if (o_frame_cnt !== seed + 8'd1) begin
        fails++; $display("FAIL frame_cnt seed=%0h got %0d want %0d", seed, o_frame_cnt, seed + 8'd1);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_all !== 35'd0) begin
      fails++; $display("FAIL reset_outputs got %h want 0", o_all);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      fails++; $display("FAIL reset_idle busy got %b want 0", o_busy);
    end
  endtask

  task automatic test_single_frame();
    @(negedge clk);
    start = 1'b1;
    frame_watch(8'h00, 1, 1'b0, 1000, 0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    start = 1'b1;
    for (int f = 0; f < 3; f++) frame_watch(8'(f), 1, 1'b1, 1000, 0);
    start = 1'b0;
  endtask

  task automatic test_fault();
    @(negedge clk);
    corrupt1 = 1'b1;
    start    = 1'b1;
    frame_watch(8'h03, 1, 1'b0, 1000, 2);
    corrupt1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 7'd2) begin
      fails++; $display("FAIL err_hold got %b/%0d want 1/2", o_err, o_err_cnt);
    end
    start = 1'b1;
    frame_watch(8'h04, 1, 1'b0, 1000, 0);
  endtask

  task automatic test_wrap();
    apply_reset();
    start = 1'b1;
    for (int f = 0; f < 256; f++) frame_watch(8'(f), 1, 1'b1, 1000, 0);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (o_frame_cnt !== 8'd0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL wrap got frame_cnt=%0d busy=%b want 0/0", o_frame_cnt, o_busy);
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    frame_watch(8'h00, 1, 1'b0, 1000, 0);
    @(negedge clk);
    start = 1'b1;
    frame_watch(8'h01, 1, 1'b0, 80, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (o_all !== 35'd0) begin
      fails++; $display("FAIL mid_reset_outputs got %h want 0", o_all);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        fails++; $display("FAIL post_reset cycle=%0d got done=%b busy=%b want 0/0", c, o_done, o_busy);
      end
    end
    start = 1'b1;
    frame_watch(8'h00, 1, 1'b0, 1000, 0);
  endtask

  task automatic test_rd_lat3();
    apply_reset();
    sel   = 1'b1;
    start = 1'b1;
    frame_watch(8'h00, 3, 1'b0, 1000, 0);
    @(negedge clk);
    corrupt3 = 1'b1;
    start    = 1'b1;
    frame_watch(8'h01, 3, 1'b0, 1000, 2);
    corrupt3 = 1'b0;
    sel      = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fault();
    test_wrap();
    test_mid_reset();
    test_rd_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
